// File: rtl/clock_pkg.sv
// Shared clock-chain types and digit limits.
// Used by the min/sec stage, the hour stage and the display decoder.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t DIGIT_MAX   = 4'd9;
  localparam bcd_t TENS_MAX_60 = 4'd5;

  // True when a mod-60 BCD pair reads 59.
  function automatic logic at_59(
    input bcd_t tens,
    input bcd_t units
  );
    return (tens == TENS_MAX_60) &&
           (units == DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter 00..59 with clear.
// carry is combinational: high when inc wraps 59 -> 00.
module bcd_mod60
  import clock_pkg::*;
(
  input  logic       in_clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       carry
);

  bcd_t t_q;
  bcd_t u_q;

  assign tens  = t_q;
  assign units = u_q;
  assign carry = inc & ~clr & at_59(t_q, u_q);

  // Digit registers: clear wins, else BCD increment.
  // Out-of-range values fold back to 0 rather than
  // counting further.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      t_q <= '0;
      u_q <= '0;
    end else if (clr) begin
      t_q <= '0;
      u_q <= '0;
    end else if (inc) begin
      if (u_q >= DIGIT_MAX) begin
        u_q <= '0;
        if (t_q >= TENS_MAX_60)
          t_q <= '0;
        else
          t_q <= t_q + 4'd1;
      end else begin
        u_q <= u_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/min_sec_counter.sv
// Seconds/minutes timebase ahead of the hour counter.
// Prescaler, input synchronisers, set logic, hour pulse.
module min_sec_counter
  import clock_pkg::*;
#(
  parameter int DIV = 1000
) (
  input  logic       in_clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clr_sec,
  input  logic       set_min,
  input  logic       set_hr,
  output logic [3:0] s1,
  output logic [3:0] s10,
  output logic [3:0] m1,
  output logic [3:0] m10,
  output logic       sec_tick,
  output logic       hour_out
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

  logic [PW-1:0] p;
  logic [1:0]    clr_sy;
  logic [1:0]    min_sy;
  logic [1:0]    hr_sy;
  logic          min_prev;
  logic          hr_prev;

  logic clr_lvl;
  logic min_edge;
  logic hr_edge;
  logic tick;
  logic sec_carry;
  logic min_inc;
  logic min_carry;
  logic hr_req;

  assign clr_lvl  = clr_sy[1];
  assign min_edge = min_sy[1] & ~min_prev;
  assign hr_edge  = hr_sy[1] & ~hr_prev;

  // A second elapses on the last prescaler count;
  // a clear in the same cycle swallows it.
  assign tick = run & ~clr_lvl & (p == P_LAST);

  // Set buttons only act while stopped.
  assign min_inc = sec_carry | (~run & min_edge);
  assign hr_req  = min_carry | (~run & hr_edge);

  // Two-flop synchronisers plus edge history.
  // History keeps tracking while running so a
  // held button does not fire when run drops.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      clr_sy   <= '0;
      min_sy   <= '0;
      hr_sy    <= '0;
      min_prev <= 1'b0;
      hr_prev  <= 1'b0;
    end else begin
      clr_sy   <= {clr_sy[0], clr_sec};
      min_sy   <= {min_sy[0], set_min};
      hr_sy    <= {hr_sy[0], set_hr};
      min_prev <= min_sy[1];
      hr_prev  <= hr_sy[1];
    end
  end

  // Prescaler: cleared by clr_sec, frozen when stopped.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst)
      p <= '0;
    else if (clr_lvl)
      p <= '0;
    else if (run) begin
      if (p == P_LAST)
        p <= '0;
      else
        p <= p + 1'b1;
    end
  end

  bcd_mod60 u_sec (
    .in_clk (in_clk),
    .rst    (rst),
    .inc    (tick),
    .clr    (clr_lvl),
    .tens   (s10),
    .units  (s1),
    .carry  (sec_carry)
  );

  bcd_mod60 u_min (
    .in_clk (in_clk),
    .rst    (rst),
    .inc    (min_inc),
    .clr    (1'b0),
    .tens   (m10),
    .units  (m1),
    .carry  (min_carry)
  );

  // Output pulses line up with the new digits.
  // hour_out is forced low after a high cycle so
  // adjacent requests never merge into one edge.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      sec_tick <= 1'b0;
      hour_out <= 1'b0;
    end else begin
      sec_tick <= tick;
      hour_out <= hr_req & ~hour_out;
    end
  end

endmodule
